// File: rtl/matrix_line_ctrl_if.sv
// Pixel-stream / window-datapath bundle for matrix_line_ctrl.
// master = pixel source and window consumer, slave = matrix_line_ctrl.
interface matrix_line_ctrl_if #(
  parameter int WIDTH = 24
);
  logic             sof;
  logic             pix_valid;
  logic [WIDTH-1:0] pix_data;
  logic             win_valid;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic [9:0]       col_cnt;
  logic [8:0]       row_cnt;
  logic             frame_done;
  logic             sof_err;

  modport master (
    output sof, pix_valid, pix_data,
    input  win_valid, din1, din2, din3, col_cnt, row_cnt, frame_done, sof_err
  );

  modport slave (
    input  sof, pix_valid, pix_data,
    output win_valid, din1, din2, din3, col_cnt, row_cnt, frame_done, sof_err
  );
endinterface

// File: rtl/matrix_line_ctrl.sv
// Line-buffer front end for a 3x3 window filter: delivers three vertically aligned pixels.
// Optional macro BORDER_REPLICATE_EN replicates the top border so every pixel yields a window.
module matrix_line_ctrl #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 640,
  parameter int PIC_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_line_ctrl_if.slave  bus
);
  localparam int         AW       = $clog2(PIC_WIDTH);
  localparam logic [9:0] COL_LAST = 10'(PIC_WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(PIC_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t           state_r;
  logic [9:0]       col_pos_r;
  logic [8:0]       row_pos_r;
  logic [WIDTH-1:0] lb0 [PIC_WIDTH];
  logic [WIDTH-1:0] lb1 [PIC_WIDTH];

  logic             in_frame_s;
  logic             accept_s;
  logic [9:0]       col_acc_s;
  logic [8:0]       row_acc_s;
  logic             last_col_s;
  logic [AW-1:0]    idx_s;
  logic [WIDTH-1:0] rd0_s;
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] d1_s;
  logic [WIDTH-1:0] d2_s;
  logic             win_s;

  // Acceptance, position of the accepted pixel and window selection.
  always_comb begin
    in_frame_s = (state_r == FILL) || (state_r == RUN);
    accept_s   = bus.pix_valid && (bus.sof || in_frame_s);
    if (bus.sof) begin
      col_acc_s = 10'd0;
      row_acc_s = 9'd0;
    end else begin
      col_acc_s = col_pos_r;
      row_acc_s = row_pos_r;
    end
    last_col_s = (col_acc_s == COL_LAST);
    idx_s      = col_acc_s[AW-1:0];
    rd0_s      = lb0[idx_s];
    rd1_s      = lb1[idx_s];
`ifdef BORDER_REPLICATE_EN
    win_s = accept_s;
    if (row_acc_s == 9'd0) begin
      d2_s = bus.pix_data;
      d1_s = bus.pix_data;
    end else if (row_acc_s == 9'd1) begin
      d2_s = rd0_s;
      d1_s = rd0_s;
    end else begin
      d2_s = rd0_s;
      d1_s = rd1_s;
    end
`else
    win_s = accept_s && (row_acc_s >= 9'd2);
    d2_s  = rd0_s;
    d1_s  = rd1_s;
`endif
  end

  // Frame sequencer: state, next pixel position, frame_done and sticky sof_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      col_pos_r      <= 10'd0;
      row_pos_r      <= 9'd0;
      bus.frame_done <= 1'b0;
      bus.sof_err    <= 1'b0;
    end else begin
      bus.frame_done <= (state_r == DONE);
      if (bus.sof && in_frame_s) begin
        bus.sof_err <= 1'b1;
      end
      if (accept_s) begin
        col_pos_r <= last_col_s ? 10'd0 : col_acc_s + 10'd1;
        row_pos_r <= (last_col_s && (row_acc_s != ROW_LAST)) ? row_acc_s + 9'd1 : row_acc_s;
      end else if (bus.sof) begin
        col_pos_r <= 10'd0;
        row_pos_r <= 9'd0;
      end
      case (state_r)
        IDLE: state_r <= bus.sof ? FILL : IDLE;
        FILL: begin
          if (bus.sof) begin
            state_r <= FILL;
          end else if (accept_s && last_col_s && (row_acc_s == 9'd1)) begin
            state_r <= RUN;
          end else begin
            state_r <= FILL;
          end
        end
        RUN: begin
          if (bus.sof) begin
            state_r <= FILL;
          end else if (accept_s && last_col_s && (row_acc_s == ROW_LAST)) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE:    state_r <= bus.sof ? FILL : IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Registered window outputs; values and position hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.win_valid <= 1'b0;
      bus.din1      <= '0;
      bus.din2      <= '0;
      bus.din3      <= '0;
      bus.col_cnt   <= 10'd0;
      bus.row_cnt   <= 9'd0;
    end else begin
      bus.win_valid <= win_s;
      if (accept_s) begin
        bus.din3    <= bus.pix_data;
        bus.din2    <= d2_s;
        bus.din1    <= d1_s;
        bus.col_cnt <= col_acc_s;
        bus.row_cnt <= row_acc_s;
      end
    end
  end

  // Line buffers: old lb0 entry moves to lb1 as the new pixel lands in lb0.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1[idx_s] <= lb0[idx_s];
      lb0[idx_s] <= bus.pix_data;
    end
  end
endmodule

// File: tb/tb_matrix_line_ctrl.sv
// Self-checking bench for matrix_line_ctrl (4x4 picture): vector table plus frame sequences,
// with per-cycle expectations queued at drive time and compared one cycle later.
module tb_matrix_line_ctrl;
  localparam int WIDTH = 24;
  localparam int PW    = 4;
  localparam int PH    = 4;

  typedef struct packed {
    logic        win;
    logic [23:0] d1;
    logic [23:0] d2;
    logic [23:0] d3;
    logic [9:0]  col;
    logic [8:0]  row;
    logic        done;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        sof;
    logic        valid;
    logic [23:0] data;
    exp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_line_ctrl_if #(.WIDTH(WIDTH)) bus ();

  matrix_line_ctrl #(
    .WIDTH(WIDTH), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          win_seen = 0;
  exp_t        sb[$];
  exp_t        m_e;
  logic [9:0]  last_col = 10'd0;
  logic [8:0]  last_row = 9'd0;
  logic        exp_err = 1'b0;
  vec_t        tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic w, input logic [23:0] a, input logic [23:0] b,
                              input logic [23:0] c, input logic [9:0] col, input logic [8:0] row,
                              input logic done, input logic err);
    exp_t e;
    e.win = w; e.d1 = a; e.d2 = b; e.d3 = c;
    e.col = col; e.row = row; e.done = done; e.err = err;
    return e;
  endfunction

  function automatic logic [23:0] pix(input logic [23:0] base, input int r, input int c);
    return base + 24'(r * 16 + c);
  endfunction

  task automatic drive(input logic s, input logic v, input logic [23:0] d, input exp_t e);
    @(negedge clk);
    bus.sof       = s;
    bus.pix_valid = v;
    bus.pix_data  = d;
    sb.push_back(e);
  endtask

  task automatic idle_cycle(input logic done);
    drive(1'b0, 1'b0, 24'h0, mk(1'b0, 24'h0, 24'h0, 24'h0, last_col, last_row, done, exp_err));
  endtask

  // One frame of npix pixels in raster order; restart marks a sof issued mid-frame.
  task automatic run_frame(input logic [23:0] base, input bit gap, input bit sof_alone,
                           input int npix, input bit restart);
    int          r;
    int          c;
    int          wins;
    logic        w;
    logic [23:0] d1;
    logic [23:0] d2;
    logic [23:0] d3;
    wins = 0;
    @(posedge clk);
    #2;
    win_seen = 0;
    if (sof_alone) begin
      drive(1'b1, 1'b0, 24'h0, mk(1'b0, 24'h0, 24'h0, 24'h0, last_col, last_row, 1'b0, exp_err));
    end
    for (int i = 0; i < npix; i++) begin
      r = i / PW;
      c = i % PW;
      if (i == 0 && restart) exp_err = 1'b1;
      d3 = pix(base, r, c);
`ifdef BORDER_REPLICATE_EN
      w = 1'b1;
      if (r == 0) begin
        d1 = d3; d2 = d3;
      end else if (r == 1) begin
        d1 = pix(base, 0, c); d2 = d1;
      end else begin
        d1 = pix(base, r - 2, c); d2 = pix(base, r - 1, c);
      end
`else
      w = (r >= 2);
      d1 = w ? pix(base, r - 2, c) : 24'h0;
      d2 = w ? pix(base, r - 1, c) : 24'h0;
`endif
      if (w) wins++;
      last_col = 10'(c);
      last_row = 9'(r);
      drive((i == 0) && !sof_alone, 1'b1, d3, mk(w, d1, d2, d3, last_col, last_row, 1'b0, exp_err));
      if (gap && (i != PW * PH - 1)) begin
        drive(1'b0, 1'b0, ~d3, mk(1'b0, 24'h0, 24'h0, 24'h0, last_col, last_row, 1'b0, exp_err));
      end
    end
    idle_cycle(npix == PW * PH);
    idle_cycle(1'b0);
    @(posedge clk);
    #2;
    chk("window_count", 32'(win_seen), 32'(wins));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_win_valid"}, 32'(bus.win_valid), 32'd0);
    chk({tag, "_din1"}, 32'(bus.din1), 32'd0);
    chk({tag, "_din2"}, 32'(bus.din2), 32'd0);
    chk({tag, "_din3"}, 32'(bus.din3), 32'd0);
    chk({tag, "_col_cnt"}, 32'(bus.col_cnt), 32'd0);
    chk({tag, "_row_cnt"}, 32'(bus.row_cnt), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_sof_err"}, 32'(bus.sof_err), 32'd0);
  endtask

  // Scoreboard: compare each cycle's outputs one edge after its stimulus.
  always begin
    @(posedge clk);
    #1;
    if (bus.win_valid) win_seen++;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      chk("win_valid", 32'(bus.win_valid), 32'(m_e.win));
      chk("col_cnt", 32'(bus.col_cnt), 32'(m_e.col));
      chk("row_cnt", 32'(bus.row_cnt), 32'(m_e.row));
      chk("frame_done", 32'(bus.frame_done), 32'(m_e.done));
      chk("sof_err", 32'(bus.sof_err), 32'(m_e.err));
      if (m_e.win) begin
        chk("din1", 32'(bus.din1), 32'(m_e.d1));
        chk("din2", 32'(bus.din2), 32'(m_e.d2));
        chk("din3", 32'(bus.din3), 32'(m_e.d3));
      end
    end else if (bus.win_valid) begin
      tests++;
      fails++;
      $display("FAIL spurious_win_valid: got 1, expected 0 at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = {1'b0, 1'b1, 24'hAAAAAA, mk(1'b0, 24'h0, 24'h0, 24'h0, 10'd0, 9'd0, 1'b0, 1'b0)};
    tbl[1] = {1'b0, 1'b1, 24'h123456, mk(1'b0, 24'h0, 24'h0, 24'h0, 10'd0, 9'd0, 1'b0, 1'b0)};
    tbl[2] = {1'b0, 1'b0, 24'h0,      mk(1'b0, 24'h0, 24'h0, 24'h0, 10'd0, 9'd0, 1'b0, 1'b0)};
    tbl[3] = {1'b0, 1'b1, 24'h000055, mk(1'b0, 24'h0, 24'h0, 24'h0, 10'd0, 9'd0, 1'b0, 1'b0)};

    bus.sof = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = 24'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Idle: pix_valid without sof must be ignored.
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].sof, tbl[i].valid, tbl[i].data, tbl[i].exp);
    end
    idle_cycle(1'b0);
    @(posedge clk);
    #2;
    chk("idle_din3", 32'(bus.din3), 32'd0);

    run_frame(24'h000000, 1'b0, 1'b0, PW * PH, 1'b0);
    run_frame(24'h000000, 1'b1, 1'b1, PW * PH, 1'b0);
    run_frame(24'h000100, 1'b0, 1'b0, 6, 1'b0);
    run_frame(24'h000200, 1'b0, 1'b0, PW * PH, 1'b1);
    run_frame(24'h000300, 1'b1, 1'b0, PW * PH, 1'b0);
    run_frame(24'h000400, 1'b0, 1'b0, 9, 1'b0);

    // Reset mid-frame: outputs clear at once, including the sticky error.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_err = 1'b0;
    last_col = 10'd0;
    last_row = 9'd0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 24'h777777, mk(1'b0, 24'h0, 24'h0, 24'h0, 10'd0, 9'd0, 1'b0, 1'b0));
    idle_cycle(1'b0);
    run_frame(24'h000500, 1'b0, 1'b0, PW * PH, 1'b0);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
